// File: rtl/perisph_pkg.sv
// Shared peripheral-bus definitions: address map, arbiter FSM encoding,
// master index type and the bus request payload.
package perisph_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ACC_CNT_W = 4;

  localparam logic [ADDR_W-1:0] LED_ADDR       = 8'hF0;
  localparam logic [ADDR_W-1:0] SW_ADDR        = 8'hF1;
  localparam logic [ADDR_W-1:0] BTN_ADDR       = 8'hF2;
  localparam logic [ADDR_W-1:0] SSEG_MSB_ADDR  = 8'hF3;
  localparam logic [ADDR_W-1:0] SSEG_LSB_ADDR  = 8'hF4;
  localparam logic [ADDR_W-1:0] SDCM_SEL_ADDR  = 8'hF5;
  localparam logic [ADDR_W-1:0] SDCM_DATA_ADDR = 8'hF6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  // 0 = m0 (CPU), 1 = m1 (debug port)
  typedef logic master_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/perisph_rr_pick.sv
// Two-way round-robin chooser: among eligible requesters, the one that did
// not win last time takes a tie.
module perisph_rr_pick
  import perisph_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] elig_i,
  input  master_t    rr_last_i,
  output master_t    gnt_c_o,
  output logic       gnt_valid_c_o
);

  logic [1:0] cand;

  assign cand          = req_i & elig_i;
  assign gnt_valid_c_o = |cand;

  always_comb begin
    gnt_c_o = 1'b0;
    if (&cand) begin
      gnt_c_o = ~rr_last_i;
    end else if (cand[1]) begin
      gnt_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/perisph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between CPU (m0) and debug
// port (m1), with an SDCM select/data lock. Define PERISPH_ARB_LOCK_TIMEOUT_EN
// to release a stale lock after LOCK_TIMEOUT cycles.
module perisph_bus_arbiter
  import perisph_pkg::*;
#(
  parameter int unsigned       ACCESS_CYCLES = 2,
  parameter logic [ADDR_W-1:0] SDCM_SADDR    = SDCM_SEL_ADDR,
  parameter logic [ADDR_W-1:0] SDCM_DADDR    = SDCM_DATA_ADDR,
  parameter int unsigned       LOCK_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              p_valid_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_addr_o,
  output logic [DATA_W-1:0] p_wdata_o,
  input  logic [DATA_W-1:0] p_rdata_i,
  output logic              locked_o,
  output logic              lock_owner_o,
  output logic              lock_timeout_o
);

  arb_state_t           state_q, state_d;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d;
  master_t              gnt_q, gnt_d;
  master_t              rr_last_q, rr_last_d;
  logic                 p_valid_q, p_valid_d;
  bus_req_t             p_req_q, p_req_d;
  logic                 m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]    m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                 locked_q, locked_d;
  master_t              lock_owner_q, lock_owner_d;

  bus_req_t   m0_bus, m1_bus;
  logic [1:0] elig;
  master_t    pick_gnt;
  logic       pick_valid;

  assign m0_bus = '{we: m0_we_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1_bus = '{we: m1_we_i, addr: m1_addr_i, wdata: m1_wdata_i};

  // A locked bus is only offered to the lock owner.
  assign elig[0] = !locked_q || (lock_owner_q == 1'b0);
  assign elig[1] = !locked_q || (lock_owner_q == 1'b1);

  perisph_rr_pick u_pick (
    .req_i         ({m1_req_i, m0_req_i}),
    .elig_i        (elig),
    .rr_last_i     (rr_last_q),
    .gnt_c_o       (pick_gnt),
    .gnt_valid_c_o (pick_valid)
  );

`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_pulse_q, tmo_pulse_d;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    rr_last_d    = rr_last_q;
    p_valid_d    = p_valid_q;
    p_req_d      = p_req_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
    tmo_cnt_d   = '0;
    tmo_pulse_d = 1'b0;
    if (locked_q) begin
      if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
        locked_d    = 1'b0;
        tmo_pulse_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          p_req_d   = pick_gnt ? m1_bus : m0_bus;
          gnt_d     = pick_gnt;
          rr_last_d = pick_gnt;
          cnt_d     = ACC_CNT_W'(ACCESS_CYCLES - 1);
          p_valid_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          p_valid_d = 1'b0;
          state_d   = ST_ACK;
          if (gnt_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = p_rdata_i;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = p_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - ACC_CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        // Completed SDCM select write opens (or refreshes) the lock; the
        // owner's data access closes it.
        if (p_req_q.we && (p_req_q.addr == SDCM_SADDR)) begin
          locked_d     = 1'b1;
          lock_owner_d = gnt_q;
`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end else if ((p_req_q.addr == SDCM_DADDR) && locked_q && (lock_owner_q == gnt_q)) begin
          locked_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
    if (!locked_d) tmo_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      rr_last_q    <= 1'b1;
      p_valid_q    <= 1'b0;
      p_req_q      <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      rr_last_q    <= rr_last_d;
      p_valid_q    <= p_valid_d;
      p_req_q      <= p_req_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
    end
  end

`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign lock_timeout_o = tmo_pulse_q;
`else
  assign lock_timeout_o = 1'b0;
`endif

  assign p_valid_o    = p_valid_q;
  assign p_we_o       = p_req_q.we;
  assign p_addr_o     = p_req_q.addr;
  assign p_wdata_o    = p_req_q.wdata;
  assign m0_ack_o     = m0_ack_q;
  assign m1_ack_o     = m1_ack_q;
  assign m0_rdata_o   = m0_rdata_q;
  assign m1_rdata_o   = m1_rdata_q;
  assign locked_o     = locked_q;
  assign lock_owner_o = lock_owner_q;

endmodule

// File: tb/tb_perisph_bus_arbiter.sv
// Scoreboard bench for perisph_bus_arbiter: expected bus accesses and acks are
// queued as stimulus is issued and checked as the DUT produces them.
module tb_perisph_bus_arbiter;
  import perisph_pkg::*;

  localparam int ACC = 2;

  typedef struct packed {
    logic       m;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack_o, m1_ack_o;
  logic [7:0] m0_rdata_o, m1_rdata_o;
  logic       p_valid_o, p_we_o;
  logic [7:0] p_addr_o, p_wdata_o, p_rdata;
  logic       locked_o, lock_owner_o, lock_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  acc_t exp_bus_q[$];
  acc_t exp_ack_q[$];
  int pv_cnt;

  always #5 clk = ~clk;

  perisph_bus_arbiter #(.ACCESS_CYCLES(ACC), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
    .p_valid_o(p_valid_o), .p_we_o(p_we_o), .p_addr_o(p_addr_o), .p_wdata_o(p_wdata_o),
    .p_rdata_i(p_rdata),
    .locked_o(locked_o), .lock_owner_o(lock_owner_o), .lock_timeout_o(lock_timeout_o)
  );

  function automatic logic [7:0] periph_data(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Peripheral returns valid data only on the last cycle of an access.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv_cnt <= 0;
    else        pv_cnt <= p_valid_o ? pv_cnt + 1 : 0;
  end
  assign p_rdata = (pv_cnt == ACC - 1) ? periph_data(p_addr_o) : ~periph_data(p_addr_o);

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_acc(input logic m, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    exp_bus_q.push_back('{m: m, we: we, addr: addr, wdata: wdata});
    exp_ack_q.push_back('{m: m, we: we, addr: addr, wdata: wdata});
  endtask

  task automatic drive_req(input logic m, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    logic got;
    got = 1'b0;
    if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = m ? m1_ack_o : m0_ack_o;
    end
    check_eq(m ? "m1_ack_wait" : "m0_ack_wait", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    exp_bus_q.delete();
    exp_ack_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", 64'({p_valid_o, p_we_o, p_addr_o, p_wdata_o, m0_ack_o, m1_ack_o,
                              m0_rdata_o, m1_rdata_o, locked_o, lock_owner_o, lock_timeout_o}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Bus and ack monitor
  logic mon_prev_v = 1'b0;
  int   mon_vcnt   = 0;
  acc_t cur_bus;
  acc_t cur_ack;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_v = 1'b0;
      mon_vcnt   = 0;
    end else begin
      if (p_valid_o) begin
        if (!mon_prev_v) begin
          mon_vcnt = 0;
          if (exp_bus_q.size() == 0) check_eq("bus_unexpected", 64'(p_valid_o), 64'd0);
          else cur_bus = exp_bus_q.pop_front();
        end
        mon_vcnt++;
        check_eq("bus_addr", 64'(p_addr_o), 64'(cur_bus.addr));
        check_eq("bus_we", 64'(p_we_o), 64'(cur_bus.we));
        check_eq("bus_wdata", 64'(p_wdata_o), 64'(cur_bus.wdata));
      end else if (mon_prev_v) begin
        check_eq("bus_width", 64'(mon_vcnt), 64'(ACC));
      end
      mon_prev_v = p_valid_o;
      if (m0_ack_o || m1_ack_o) begin
        check_eq("ack_onehot", 64'(m0_ack_o & m1_ack_o), 64'd0);
        if (exp_ack_q.size() == 0) begin
          check_eq("ack_unexpected", 64'(m0_ack_o | m1_ack_o), 64'd0);
        end else begin
          cur_ack = exp_ack_q.pop_front();
          check_eq("ack_master", 64'(m1_ack_o), 64'(cur_ack.m));
          check_eq("ack_rdata", 64'(m1_ack_o ? m1_rdata_o : m0_rdata_o), 64'(periph_data(cur_ack.addr)));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] rd0 [3];
  logic [7:0] rd1 [3];

  initial begin
    int acks, vcyc;
    logic seen;
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    rd0[0] = SW_ADDR;  rd0[1] = SSEG_LSB_ADDR; rd0[2] = LED_ADDR;
    rd1[0] = BTN_ADDR; rd1[1] = SSEG_MSB_ADDR; rd1[2] = SW_ADDR;

    // Single LED write: latency and strobe width
    apply_reset();
    @(negedge clk);
    check_eq("post_rst_outs", 64'({p_valid_o, m0_ack_o, m1_ack_o, locked_o, lock_owner_o, lock_timeout_o}), 64'd0);
    expect_acc(1'b0, 1'b1, LED_ADDR, 8'h3C);
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = LED_ADDR; m0_wdata = 8'h3C;
    @(negedge clk);
    check_eq("lat_idle_valid", 64'(p_valid_o), 64'd0);
    for (int i = 0; i < ACC; i++) begin
      @(negedge clk);
      check_eq("lat_valid", 64'(p_valid_o), 64'd1);
      check_eq("lat_addr", 64'(p_addr_o), 64'(LED_ADDR));
      check_eq("lat_wdata", 64'(p_wdata_o), 64'h3C);
    end
    @(negedge clk);
    check_eq("lat_ack", 64'({p_valid_o, m0_ack_o}), 64'b01);
    @(posedge clk); #1;
    m0_req = 1'b0;

    // DADDR access with no lock leaves the lock alone
    expect_acc(1'b0, 1'b0, SDCM_DATA_ADDR, 8'h00);
    drive_req(1'b0, 1'b0, SDCM_DATA_ADDR, 8'h00);
    @(negedge clk);
    check_eq("daddr_nolock", 64'(locked_o), 64'd0);

    // Simultaneous continuous reads alternate starting with m0
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      expect_acc(1'b0, 1'b0, rd0[i], 8'h00);
      expect_acc(1'b1, 1'b0, rd1[i], 8'h00);
    end
    fork
      for (int i = 0; i < 3; i++) drive_req(1'b0, 1'b0, rd0[i], 8'h00);
      for (int j = 0; j < 3; j++) drive_req(1'b1, 1'b0, rd1[j], 8'h00);
    join

    // SDCM lock held by m1 blocks m0 until m1's data access
    apply_reset();
    expect_acc(1'b1, 1'b1, SDCM_SEL_ADDR, 8'h07);
    drive_req(1'b1, 1'b1, SDCM_SEL_ADDR, 8'h07);
    @(negedge clk);
    check_eq("lock_set", 64'({locked_o, lock_owner_o}), 64'b11);
    expect_acc(1'b1, 1'b1, LED_ADDR, 8'h81);
    expect_acc(1'b1, 1'b0, BTN_ADDR, 8'h00);
    expect_acc(1'b1, 1'b0, SDCM_DATA_ADDR, 8'h00);
    expect_acc(1'b0, 1'b0, SW_ADDR, 8'h00);
    fork
      drive_req(1'b0, 1'b0, SW_ADDR, 8'h00);
      begin
        drive_req(1'b1, 1'b1, LED_ADDR, 8'h81);
        drive_req(1'b1, 1'b0, BTN_ADDR, 8'h00);
        drive_req(1'b1, 1'b0, SDCM_DATA_ADDR, 8'h00);
        @(negedge clk);
        check_eq("lock_clear", 64'(locked_o), 64'd0);
        @(negedge clk);
        check_eq("m0_after_unlock", 64'({p_valid_o, p_addr_o}), 64'({1'b1, SW_ADDR}));
      end
    join

    // Reset during the second ACCESS cycle, pending m1 request served after
    apply_reset();
    expect_acc(1'b1, 1'b1, SDCM_SEL_ADDR, 8'h01);
    drive_req(1'b1, 1'b1, SDCM_SEL_ADDR, 8'h01);
    exp_bus_q.push_back('{m: 1'b1, we: 1'b1, addr: LED_ADDR, wdata: 8'hAA});
    expect_acc(1'b1, 1'b1, LED_ADDR, 8'hAA);
    fork
      drive_req(1'b1, 1'b1, LED_ADDR, 8'hAA);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = p_valid_o;
        end
        check_eq("rst_pre_valid", 64'({seen, locked_o}), 64'b11);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 64'({p_valid_o, m0_ack_o, m1_ack_o, locked_o}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    join
    @(negedge clk);
    check_eq("rst_after_lock", 64'(locked_o), 64'd0);

    // m0 drops req mid-access: one ack, no second access
    apply_reset();
    expect_acc(1'b0, 1'b0, BTN_ADDR, 8'h00);
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = BTN_ADDR; m0_wdata = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = p_valid_o;
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    acks = 0; vcyc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      acks += int'(m0_ack_o);
      vcyc += int'(p_valid_o);
    end
    check_eq("drop_ack_cnt", 64'(acks), 64'd1);
    check_eq("drop_valid_cyc", 64'(vcyc), 64'(ACC - 1));

`ifdef PERISPH_ARB_LOCK_TIMEOUT_EN
    // Stale m0 lock expires after LOCK_TIMEOUT cycles, then m1 proceeds
    apply_reset();
    expect_acc(1'b0, 1'b1, SDCM_SEL_ADDR, 8'h11);
    drive_req(1'b0, 1'b1, SDCM_SEL_ADDR, 8'h11);
    expect_acc(1'b1, 1'b0, LED_ADDR, 8'h00);
    fork
      drive_req(1'b1, 1'b0, LED_ADDR, 8'h00);
      begin
        int k;
        k = -1;
        for (int i = 0; i < 20 && k < 0; i++) begin
          @(negedge clk);
          if (lock_timeout_o) begin
            k = i;
            check_eq("tmo_unlocked", 64'(locked_o), 64'd0);
          end
        end
        check_eq("tmo_cycle", 64'(k), 64'd8);
      end
    join
`endif

    repeat (3) @(negedge clk);
    check_eq("bus_q_left", 64'(exp_bus_q.size()), 64'd0);
    check_eq("ack_q_left", 64'(exp_ack_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perisph_bus_arbiter.md
Name: perisph_bus_arbiter

Overview:
- Shares the single 8-bit peripheral I/O bus (LEDs, switches, buttons, 7-seg, SDCM) between two masters: m0 (CPU) and m1 (debug/monitor port).
- Sits upstream of the peripheral address decoder.
- Arbitrates requests round-robin and inserts a fixed number of wait states per access.
- Keeps the two-step SDCM access (select register write, then data register access) atomic per master.

Parameters:
- ACCESS_CYCLES, 2: cycles p_valid is held per access; legal range 1..15.
- SDCM_SADDR, 8'hF5: SDCM select-register address; default comes from the shared package.
- SDCM_DADDR, 8'hF6: SDCM data-register address; default comes from the shared package.
- LOCK_TIMEOUT, 64: cycles before a stale SDCM lock is released. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- m0_req, m1_req  in  1  access request; held until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  8  peripheral address.
- m0_wdata, m1_wdata  in  8  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  8  read data; valid in the ack cycle.
- p_valid  out  1  bus access strobe to the decoder/peripherals.
- p_we  out  1  registered write enable.
- p_addr  out  8  registered address.
- p_wdata  out  8  registered write data.
- p_rdata  in  8  peripheral read data; sampled on the last access cycle.
- locked  out  1  SDCM lock active.
- lock_owner  out  1  master holding the lock (0 = m0).
- lock_timeout  out  1  one-cycle pulse when the lock expires.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; rr_last = 1 (m0 wins the first tie); lock cleared; counters 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Choose an eligible requester. A master is eligible if it requests and either no lock is active or it is lock_owner.
  - If both are eligible, grant the one that is not rr_last.
  - On grant: register addr/we/wdata into p_*, set gnt, set rr_last = gnt, load wait counter = ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - p_valid = 1.
  - Decrement the counter. At 0, capture p_rdata and go to ACK.
- ACK:
  - p_valid = 0; gnt ack = 1 for this cycle only; gnt rdata = captured value.
  - Update the lock (rules below); go to IDLE.
  - rdata holds its value until the next ack to that master.
- Latency: request seen in IDLE at cycle N → p_valid high in cycles N+1..N+ACCESS_CYCLES → ack at N+ACCESS_CYCLES+1. Minimum period between accesses is ACCESS_CYCLES+2.
- p_addr, p_we and p_wdata stay stable for the entire ACCESS state and hold their last values otherwise.
- Master drops req mid-access: the access still completes and the ack still pulses. No abort.
- Lock rules (applied in ACK):
  - Write to SDCM_SADDR: locked = 1, lock_owner = gnt, timeout counter reset. A repeat SADDR write by the owner restarts the timer.
  - Access to SDCM_DADDR (read or write) by the owner: lock cleared.
  - DADDR access without a lock: performed normally, lock unaffected.
- Non-owner requesting while locked: stalls in IDLE with no ack, no error, and no loss of its request.
- Reset mid-access: p_valid drops immediately (async); no ack is issued; the lock is cleared.

Optional Feature:
- Macro PERISPH_ARB_LOCK_TIMEOUT_EN.
- When defined:
  - Counter runs while locked. Width is the smallest holding LOCK_TIMEOUT.
  - Reaching LOCK_TIMEOUT-1 clears the lock and pulses lock_timeout for 1 cycle.
  - An access already in ACCESS state completes normally.
  - If expiry and an owner DADDR ack coincide: the lock clears and lock_timeout is still pulsed.
- When undefined: no counter; the lock persists until DADDR; lock_timeout is tied to 0.

Decomposition:
- Shared package perisph_pkg holds:
  - all peripheral address constants (LED, SW, BTN, SSEG MSB/LSB, SDCM_SADDR/DADDR);
  - FSM state encoding;
  - the master-index typedef.
- One sub-module: perisph_rr_pick. Combinational two-way round-robin chooser with inputs req[1:0], elig[1:0] and rr_last; outputs gnt and gnt_valid.

Test Plan:
- m0 writes 8'h3C to LED address (ACCESS_CYCLES=2) → p_valid is high for exactly 2 cycles with p_addr/p_wdata stable; m0_ack arrives 3 cycles after req is sampled.
- m0 and m1 request reads continuously in the same cycle after reset → grants alternate m0, m1, m0, m1; each ack carries the p_rdata driven during that access's last cycle.
- m1 writes SDCM_SADDR; m0 then requests SW repeatedly:
  - m0 receives no ack while m1 has ack'ed accesses;
  - after m1 reads SDCM_DADDR: locked drops, and m0 is granted in the next IDLE.
- With PERISPH_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8: m0 writes SADDR and goes idle; m1 requests → lock_timeout pulses 8 cycles after lock set, then m1 is granted.
- rst_n is pulled low during the second ACCESS cycle → p_valid, ack and locked are 0 immediately; after release, a pending m1 request is served normally.
- m0 drops req during ACCESS → m0_ack still pulses once; no second access is started.
